// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared constants and types for the data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int DMEM_DEPTH_WORDS = 1024;
   localparam int LANES            = 4;
   localparam int LANE_W           = 8;

   typedef logic [LANES-1:0] lane_mask_t;
endpackage

`default_nettype wire

// File: rtl/data_memory_if.sv
// ============================================================================
//  Module   : data_memory_if
//  Purpose  : Request/response bus between the MEM stage and data memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_memory_if;
   logic        write_enable;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic        read_enable;
   logic [31:0] read_addr;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        read_valid;
   logic        write_done;
   logic        access_error;

   modport master (
      output write_enable, write_addr, write_data,
      output read_enable, read_addr, funct3,
      input  read_data, read_valid, write_done, access_error
   );

   modport slave (
      input  write_enable, write_addr, write_data,
      input  read_enable, read_addr, funct3,
      output read_data, read_valid, write_done, access_error
   );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Byte-lane steering, load extension and width/alignment checks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
   import dmem_pkg::*;
(
   input  wire logic [2:0]  funct3,
   input  wire logic [1:0]  st_lane,
   input  wire logic [31:0] st_data,
   input  wire logic [1:0]  ld_lane,
   input  wire logic [31:0] ld_word,
   output lane_mask_t       st_mask,
   output logic [31:0]      st_wdata,
   output logic [31:0]      ld_data,
   output logic             st_err,
   output logic             ld_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      st_mask  = '0;
      st_wdata = st_data;
      st_err   = 1'b0;
      case (funct3)
         F3_B: begin
            st_mask  = lane_mask_t'(4'b0001 << st_lane);
            st_wdata = {4{st_data[7:0]}};
         end
         F3_H: begin
            st_mask  = st_lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
            st_err   = st_lane[0];
         end
         F3_W: begin
            st_mask  = 4'b1111;
            st_err   = (st_lane != 2'b00);
         end
         default: st_err = 1'b1;
      endcase
      // A rejected store must not touch any lane.
      if (st_err) st_mask = '0;
   end

   always_comb begin
      case (ld_lane)
         2'd0:    w_byte = ld_word[7:0];
         2'd1:    w_byte = ld_word[15:8];
         2'd2:    w_byte = ld_word[23:16];
         default: w_byte = ld_word[31:24];
      endcase
      w_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
   end

   always_comb begin
      ld_data = '0;
      ld_err  = 1'b0;
      case (funct3)
         F3_B:  ld_data = {{24{w_byte[7]}}, w_byte};
         F3_BU: ld_data = {24'd0, w_byte};
         F3_H: begin
            ld_data = {{16{w_half[15]}}, w_half};
            ld_err  = ld_lane[0];
         end
         F3_HU: begin
            ld_data = {16'd0, w_half};
            ld_err  = ld_lane[0];
         end
         F3_W: begin
            ld_data = ld_word;
            ld_err  = (ld_lane != 2'b00);
         end
         default: ld_err = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
//  Module   : data_memory
//  Purpose  : Byte-lane data memory with registered, extended load responses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
   input  wire logic    clk,
   input  wire logic    reset,
   data_memory_if.slave bus
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);

   logic [31:0] r_mem [DEPTH_WORDS];

   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;
   logic [31:0]   w_rd_word;
   lane_mask_t    w_st_mask;
   logic [31:0]   w_st_wdata;
   logic [31:0]   w_ld_data;
   logic          w_st_err;
   logic          w_ld_err;
   logic          w_wr_oor;
   logic          w_rd_oor;
   logic          w_wr_err;
   logic          w_rd_err;
   logic          w_wr_commit;

   logic [31:0] r_read_data;
   logic        r_read_valid;
   logic        r_write_done;
   logic        r_access_error;

   assign w_wr_idx  = bus.write_addr[AW+1:2];
   assign w_rd_idx  = bus.read_addr[AW+1:2];
   assign w_wr_oor  = ({2'b00, bus.write_addr[31:2]} >= C_DEPTH);
   assign w_rd_oor  = ({2'b00, bus.read_addr[31:2]}  >= C_DEPTH);
   assign w_rd_word = w_rd_oor ? 32'd0 : r_mem[w_rd_idx];

   mem_lane_align u_align (
      .funct3   (bus.funct3),
      .st_lane  (bus.write_addr[1:0]),
      .st_data  (bus.write_data),
      .ld_lane  (bus.read_addr[1:0]),
      .ld_word  (w_rd_word),
      .st_mask  (w_st_mask),
      .st_wdata (w_st_wdata),
      .ld_data  (w_ld_data),
      .st_err   (w_st_err),
      .ld_err   (w_ld_err)
   );

   assign w_wr_err    = w_st_err | w_wr_oor;
   assign w_rd_err    = w_ld_err | w_rd_oor;
   assign w_wr_commit = bus.write_enable & ~w_wr_err & ~reset;

   // Array is deliberately unreset; the read above sees pre-write contents.
   always_ff @(posedge clk) begin
      if (w_wr_commit) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_st_mask[i]) r_mem[w_wr_idx][LANE_W*i +: LANE_W] <= w_st_wdata[LANE_W*i +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read_data    <= '0;
         r_read_valid   <= 1'b0;
         r_write_done   <= 1'b0;
         r_access_error <= 1'b0;
      end else begin
         r_read_valid   <= bus.read_enable;
         r_write_done   <= bus.write_enable;
         r_access_error <= (bus.write_enable & w_wr_err) | (bus.read_enable & w_rd_err);
         if (bus.read_enable) r_read_data <= w_rd_err ? 32'd0 : w_ld_data;
      end
   end

   assign bus.read_data    = r_read_data;
   assign bus.read_valid   = r_read_valid;
   assign bus.write_done   = r_write_done;
   assign bus.access_error = r_access_error;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
//  Module   : tb_data_memory
//  Purpose  : Directed and random checks of data_memory against a byte model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_memory;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [7:0]  mm [0:4095];
   logic [31:0] last_rd = 32'd0;

   data_memory_if bus();

   data_memory #(.DEPTH_WORDS(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit legal(input logic [31:0] a, input logic [2:0] f3, input bit is_store);
      bit code_ok;
      if (is_store) code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else          code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!code_ok) return 1'b0;
      if ((a % size_of(f3)) != 0) return 1'b0;
      if ((a / 4) >= 1024) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] v = 32'd0;
      int n = size_of(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra, input logic [2:0] f3);
      bit wok, rok;
      @(negedge clk);
      bus.write_enable = we;
      bus.write_addr   = wa;
      bus.write_data   = wd;
      bus.read_enable  = re;
      bus.read_addr    = ra;
      bus.funct3       = f3;
      @(posedge clk);
      wok = legal(wa, f3, 1'b1);
      rok = legal(ra, f3, 1'b0);
      if (re) last_rd = rok ? load_val(ra, f3) : 32'd0;
      if (we && wok) for (int i = 0; i < size_of(f3); i++) mm[wa + i] = wd[8*i +: 8];
      #1;
      chk("read_valid", 32'(bus.read_valid), 32'(re));
      chk("write_done", 32'(bus.write_done), 32'(we));
      chk("access_error", 32'(bus.access_error), 32'((we && !wok) || (re && !rok)));
      chk("read_data", bus.read_data, last_rd);
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, F3_W);
   endtask

   initial begin
      bus.write_enable = 1'b0;
      bus.write_addr   = '0;
      bus.write_data   = '0;
      bus.read_enable  = 1'b0;
      bus.read_addr    = '0;
      bus.funct3       = F3_W;
      repeat (3) @(negedge clk);
      chk("reset_read_data", bus.read_data, 32'd0);
      chk("reset_flags", {29'd0, bus.read_valid, bus.write_done, bus.access_error}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 32; i++) step(1'b1, 32'(i * 4), 32'd0, 1'b0, 32'd0, F3_W);

      step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, F3_W);
      chk("sw_done", 32'(bus.write_done), 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h10, F3_W);
      chk("lw_10", bus.read_data, 32'hDEADBEEF);
      step(1'b1, 32'h12, 32'h00000055, 1'b0, 32'd0, F3_B);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h10, F3_W);
      chk("lw_10_after_sb", bus.read_data, 32'hDE55BEEF);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h13, F3_B);
      chk("lb_13", bus.read_data, 32'hFFFFFFDE);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h13, F3_BU);
      chk("lbu_13", bus.read_data, 32'h000000DE);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h12, F3_H);
      chk("lh_12", bus.read_data, 32'hFFFFDE55);

      step(1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0, F3_W);
      step(1'b1, 32'h21, 32'h0000FFFF, 1'b0, 32'd0, F3_H);
      chk("sh_21_err", 32'(bus.access_error), 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h22, F3_W);
      chk("lw_22_err", {bus.read_data[30:0], bus.access_error}, 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h1000, F3_W);
      chk("lw_1000_err", {bus.read_data[30:0], bus.access_error}, 32'd1);
      step(1'b1, 32'h20, 32'h12345678, 1'b0, 32'd0, 3'b011);
      chk("f3_011_store_err", 32'(bus.access_error), 32'd1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h20, F3_W);
      chk("lw_20_unchanged", bus.read_data, 32'hCAFEF00D);

      step(1'b1, 32'h40, 32'h11111111, 1'b1, 32'h40, F3_W);
      chk("same_edge_old", bus.read_data, 32'h00000000);
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h40, F3_W);
      chk("same_edge_new", bus.read_data, 32'h11111111);

      // Async reset clears a pulse already on the outputs.
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h10, F3_W);
      #1 reset = 1'b1;
      #1;
      chk("mid_reset_valid", 32'(bus.read_valid), 32'd0);
      chk("mid_reset_data", bus.read_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus.read_enable  = 1'b1;
      bus.read_addr    = 32'h10;
      bus.write_enable = 1'b1;
      bus.write_addr   = 32'h10;
      bus.write_data   = 32'h0;
      bus.funct3       = F3_W;
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_edge_flags", {29'd0, bus.read_valid, bus.write_done, bus.access_error}, 32'd0);
      @(negedge clk);
      bus.read_enable  = 1'b0;
      bus.write_enable = 1'b0;
      reset = 1'b0;
      last_rd = 32'd0;
      step(1'b0, 32'd0, 32'd0, 1'b1, 32'h10, F3_W);
      chk("retained_10", bus.read_data, 32'hDE55BEEF);

      for (int n = 0; n < 400; n++) begin
         logic [2:0]  f3;
         logic [31:0] wa, ra;
         case ($urandom % 6)
            0: f3 = 3'($urandom % 8);
            1: f3 = F3_BU;
            2: f3 = F3_HU;
            3: f3 = F3_B;
            4: f3 = F3_H;
            default: f3 = F3_W;
         endcase
         wa = ($urandom % 10 == 0) ? 32'h1000 + ($urandom % 64) : 32'($urandom % 128);
         ra = ($urandom % 10 == 0) ? 32'hFFFFFFF0 + ($urandom % 16) : 32'($urandom % 128);
         step(1'($urandom % 2), wa, $urandom, 1'($urandom % 2), ra, f3);
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_memory.md
# data_memory

Data-memory responder for the single-cycle RISC-V core: it services the write and read requests issued by the MEM stage and returns load data. Stores are byte, halfword or word wide, with per-lane writes. Loads return registered, sign- or zero-extended data one cycle after the request, with a valid pulse. Accesses that are misaligned, out of range or of an illegal width are rejected and flagged.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clock clk.
- write_enable  in  1  store request, sampled at the rising edge; normally a one-cycle pulse.
- write_addr  in  32  byte address of the store.
- write_data  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- read_enable  in  1  load request, level, sampled at the rising edge.
- read_addr  in  32  byte address of the load.
- funct3  in  3  access width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is illegal.
- read_data  out  32  extended load result, registered.
- read_valid  out  1  one-cycle pulse: read_data is valid.
- write_done  out  1  one-cycle pulse: the store has committed or been rejected.
- access_error  out  1  one-cycle pulse, coincident with read_valid or write_done, for a rejected access.

## Operation
- Storage: DEPTH_WORDS x 32 bits, organised as four byte lanes. Word index = addr[31:2]; lane = addr[1:0]. The array is not reset, so its contents survive reset.
- Legality checks, applied per access:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - out of range: addr[31:2] >= DEPTH_WORDS;
  - illegal funct3.
  - Any of these makes the access an error.
- Store, legal: write_data[7:0] goes to lane addr[1:0] (B); write_data[15:0] goes to lanes {addr[1],0}+1..0 (H); all four lanes (W). Other lanes keep their values. BU and HU are illegal for stores.
- Store, error: no lane is written; write_done=1 and access_error=1 in the next cycle.
- Load, legal: select the byte or halfword from the addressed word. Sign-extend for B/H, zero-extend for BU/HU; W passes through.
- Load, error: read_data=0, read_valid=1 and access_error=1 in the next cycle.
- Simultaneous write_enable and read_enable: both are performed with the same funct3. The read is read-first (it returns pre-write contents), including when both target the same word. write_done and read_valid pulse together; access_error is the OR of both checks.
- read_data holds its last value until the next load completes.

## Timing
- Store commit at edge N when write_enable=1 at N. write_done pulses during cycle N+1. The stored data is visible to a load sampled at edge N+1 or later.
- Load sampled at edge N; read_data and read_valid are valid during cycle N+1. Throughput: one load per cycle.
- read_enable held high for k edges yields k read_valid pulses.
- A held write_enable writes on every edge; each write produces its own write_done pulse.
- Reset values: read_data=0, read_valid=0, write_done=0, access_error=0.
- Reset asserted mid-operation: pending pulses are cleared immediately. An edge coinciding with reset performs no write.
- Response registers: read_data, read_valid, write_done, access_error. No combinational path from inputs to outputs.

## Structure
- Shared package (dmem_pkg): funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU; DEPTH_WORDS default; lane-mask width.
- Sub-module mem_lane_align (combinational), containing:
  - store lane-mask and data replication from funct3 and addr[1:0];
  - load lane select and extension;
  - misalignment and illegal-funct3 detect.
- Top level: array, range check, response registers.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> write_done pulse at N+1; read_data=0xDEADBEEF, read_valid at the load's N+1, access_error=0.
- After the above: SB 0x55 @0x12, then LW @0x10 -> 0xDE55BEEF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDE55.
- SH @0x21 or LW @0x22 -> no lane written (word @0x20 unchanged), access_error pulse with write_done/read_valid, read_data=0.
- LW @0x1000 (DEPTH_WORDS=1024) -> read_data=0, access_error=1; funct3=011 store -> rejected, memory unchanged.
- Same-edge SW 0x11111111 @0x40 and LW @0x40 (old 0x0) -> read_data=0x0, write_done and read_valid together; next LW -> 0x11111111.
- Assert reset one cycle after a load request -> read_valid never pulses, outputs 0; memory contents are retained after release.
